mult_share_arb: RTL and testbench

//  Round-robin arbiter/scheduler sharing one pipelined signed multiplier (mult_gen_* core, external)

---
 rtl/mult_share_arb.sv | 105 ++++++++++
 tb/tb_mult_share_arb.sv | 228 ++++++++++++++++++++++
 2 files changed

// File: rtl/mult_share_arb.sv
// Round-robin arbiter sharing one pipelined signed multiplier among NREQ requesters,
// with requester IDs carried in a tag pipeline. Optional macro MULT_ARB_PRIO_EN: requester 0 has absolute priority.
module mult_share_arb #(
    parameter int unsigned NREQ     = 4,
    parameter int unsigned A_W      = 24,
    parameter int unsigned B_W      = 35,
    parameter int unsigned MULT_LAT = 3
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  en,
    input  logic [NREQ-1:0]       req,
    input  logic [NREQ*A_W-1:0]   a_in,
    input  logic [NREQ*B_W-1:0]   b_in,
    output logic [NREQ-1:0]       gnt,
    output logic [A_W-1:0]        mult_a,
    output logic [B_W-1:0]        mult_b,
    input  logic [A_W+B_W-1:0]    mult_p,
    output logic [NREQ-1:0]       res_valid,
    output logic [A_W+B_W-1:0]    res_p,
    output logic                  busy
);

    localparam int unsigned IDW  = $clog2(NREQ);
    localparam int unsigned NSTG = MULT_LAT + 1;

`ifdef MULT_ARB_PRIO_EN
    localparam bit PRIO_EN = 1'b1;
`else
    localparam bit PRIO_EN = 1'b0;
`endif

    logic [IDW-1:0]     r_ptr;
    logic [IDW-1:0]     w_gnt_idx;
    logic [IDW-1:0]     w_scan;
    logic [IDW-1:0]     w_ptr_nxt;
    logic               w_acc;
    logic [NREQ-1:0]    w_gnt;
    logic [NSTG-1:0]    r_tag_v;
    logic [IDW-1:0]     r_tag_id [NSTG];
    logic [A_W-1:0]     r_mult_a;
    logic [B_W-1:0]     r_mult_b;
    logic [NREQ-1:0]    r_res_valid;
    logic [A_W+B_W-1:0] r_res_p;

    // Scan from the pointer with wrap; in priority mode index 0 is handled up front
    // and skipped by the round-robin scan.
    always_comb begin
        w_gnt     = '0;
        w_gnt_idx = '0;
        w_scan    = '0;
        w_acc     = 1'b0;
        if (en) begin
            if (PRIO_EN && req[0]) begin
                w_acc = 1'b1;
            end else begin
                for (int unsigned k = 0; k < NREQ; k++) begin
                    w_scan = IDW'((32'(r_ptr) + k) % NREQ);
                    if (!w_acc && req[w_scan] && !(PRIO_EN && w_scan == '0)) begin
                        w_acc     = 1'b1;
                        w_gnt_idx = w_scan;
                    end
                end
            end
            if (w_acc) w_gnt[w_gnt_idx] = 1'b1;
        end
    end

    assign w_ptr_nxt = (w_gnt_idx == IDW'(NREQ - 1)) ? '0 : w_gnt_idx + 1'b1;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_ptr       <= '0;
            r_tag_v     <= '0;
            r_mult_a    <= '0;
            r_mult_b    <= '0;
            r_res_valid <= '0;
            r_res_p     <= '0;
            for (int unsigned s = 0; s < NSTG; s++) r_tag_id[s] <= '0;
        end else begin
            if (w_acc) begin
                r_mult_a <= a_in[w_gnt_idx*A_W +: A_W];
                r_mult_b <= b_in[w_gnt_idx*B_W +: B_W];
                if (!(PRIO_EN && w_gnt_idx == '0)) r_ptr <= w_ptr_nxt;
            end
            r_tag_v     <= {r_tag_v[NSTG-2:0], w_acc};
            r_tag_id[0] <= w_gnt_idx;
            for (int unsigned s = 1; s < NSTG; s++) r_tag_id[s] <= r_tag_id[s-1];
            // Last tag stage lines up with the product emerging from the multiplier.
            r_res_valid <= '0;
            if (r_tag_v[NSTG-1]) begin
                r_res_valid[r_tag_id[NSTG-1]] <= 1'b1;
                r_res_p                       <= mult_p;
            end
        end
    end

    assign gnt       = w_gnt;
    assign mult_a    = r_mult_a;
    assign mult_b    = r_mult_b;
    assign res_valid = r_res_valid;
    assign res_p     = r_res_p;
    assign busy      = (|r_tag_v) | (|r_res_valid);

endmodule

// File: tb/tb_mult_share_arb.sv
// Directed bench for mult_share_arb (NREQ=4, MULT_LAT=3) with a 3-deep signed multiplier model.
module tb_mult_share_arb;

    localparam int unsigned NREQ = 4;
    localparam int unsigned A_W  = 24;
    localparam int unsigned B_W  = 35;
    localparam int unsigned LAT  = 3;
    localparam int unsigned P_W  = A_W + B_W;

    logic                 clk;
    logic                 reset;
    logic                 en;
    logic [NREQ-1:0]      req;
    logic [NREQ*A_W-1:0]  a_in;
    logic [NREQ*B_W-1:0]  b_in;
    logic [NREQ-1:0]      gnt;
    logic [A_W-1:0]       mult_a;
    logic [B_W-1:0]       mult_b;
    logic [P_W-1:0]       mult_p;
    logic [NREQ-1:0]      res_valid;
    logic [P_W-1:0]       res_p;
    logic                 busy;

    int total = 0;
    int bad   = 0;

    logic signed [P_W-1:0] p_pipe [LAT];

    mult_share_arb #(.NREQ(NREQ), .A_W(A_W), .B_W(B_W), .MULT_LAT(LAT)) dut (
        .clk(clk), .reset(reset), .en(en), .req(req), .a_in(a_in), .b_in(b_in),
        .gnt(gnt), .mult_a(mult_a), .mult_b(mult_b), .mult_p(mult_p),
        .res_valid(res_valid), .res_p(res_p), .busy(busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) begin
        p_pipe[0] <= $signed(mult_a) * $signed(mult_b);
        for (int s = 1; s < LAT; s++) p_pipe[s] <= p_pipe[s-1];
    end
    assign mult_p = p_pipe[LAT-1];

    task automatic set_op(input int unsigned i, input logic signed [A_W-1:0] a,
                          input logic signed [B_W-1:0] b);
        a_in[i*A_W +: A_W] = a;
        b_in[i*B_W +: B_W] = b;
    endtask

    task automatic do_reset();
        reset = 1'b1; en = 1'b1; req = '0;
        @(negedge clk); @(negedge clk);
        reset = 1'b0;
    endtask

    task automatic test_reset();
        reset = 1'b1; en = 1'b1; req = '0; a_in = '0; b_in = '0;
        @(negedge clk); @(negedge clk);
        total++; if (res_valid !== 4'b0000) begin bad++; $display("FAIL reset_res_valid got=%b want=0000", res_valid); end
        total++; if (busy !== 1'b0) begin bad++; $display("FAIL reset_busy got=%b want=0", busy); end
        total++; if (mult_a !== '0 || mult_b !== '0) begin bad++; $display("FAIL reset_mult_ops got=%h/%h want=0/0", mult_a, mult_b); end
        total++; if (res_p !== '0) begin bad++; $display("FAIL reset_res_p got=%h want=0", res_p); end
        reset = 1'b0;
    endtask

    task automatic test_single();
        logic signed [P_W-1:0] e;
        e = -35;
        set_op(2, -5, 7);
        for (int m = 0; m <= 6; m++) begin
            req = (m == 0) ? 4'b0100 : 4'b0000;
            #1;
            if (m == 0) begin
                total++; if (gnt !== 4'b0100) begin bad++; $display("FAIL single_gnt got=%b want=0100", gnt); end
            end
            if (m >= 1 && m <= 4) begin
                total++; if (res_valid !== 4'b0000 || busy !== 1'b1) begin bad++; $display("FAIL single_wait m=%0d rv=%b busy=%b want 0000/1", m, res_valid, busy); end
            end
            if (m == 5) begin
                total++; if (res_valid !== 4'b0100) begin bad++; $display("FAIL single_rv got=%b want=0100", res_valid); end
                total++; if (res_p !== e) begin bad++; $display("FAIL single_p got=%0d want=%0d", $signed(res_p), e); end
            end
            if (m == 6) begin
                total++; if (res_valid !== 4'b0000 || busy !== 1'b0) begin bad++; $display("FAIL single_done rv=%b busy=%b want 0000/0", res_valid, busy); end
            end
            @(negedge clk);
        end
    endtask

    task automatic test_back_to_back();
        logic signed [P_W-1:0] exp_p [4];
        logic [NREQ-1:0] w;
        exp_p = '{-10, 40, -90, 160};
        set_op(0, 1, -10); set_op(1, 2, 20); set_op(2, 3, -30); set_op(3, 4, 40);
        do_reset();
        for (int m = 0; m <= 13; m++) begin
            req = (m < 8) ? 4'b1111 : 4'b0000;
            #1;
            if (m < 8) begin
                w = 4'b0001 << (m % 4);
                total++; if (gnt !== w) begin bad++; $display("FAIL rr_gnt m=%0d got=%b want=%b", m, gnt, w); end
            end
            if (m >= 5 && m < 13) begin
                w = 4'b0001 << ((m - 5) % 4);
                total++; if (res_valid !== w || res_p !== exp_p[(m-5)%4]) begin bad++; $display("FAIL rr_res m=%0d rv=%b p=%0d want %b/%0d", m, res_valid, $signed(res_p), w, exp_p[(m-5)%4]); end
            end
            if (m == 13) begin
                total++; if (res_valid !== 4'b0000 || busy !== 1'b0) begin bad++; $display("FAIL rr_drain rv=%b busy=%b want 0000/0", res_valid, busy); end
            end
            @(negedge clk);
        end
    endtask

    task automatic test_extremes();
        logic signed [P_W-1:0] e1, e2, one;
        one = 1;
        e1 = one <<< 57;
        e2 = (one <<< 57) - (one <<< 23) - (one <<< 34) + one;
        set_op(1, 24'sh800000, 35'sh400000000);
        set_op(3, 24'sh7FFFFF, 35'sh3FFFFFFFF);
        for (int m = 0; m <= 7; m++) begin
            req = (m == 0) ? 4'b0010 : (m == 1) ? 4'b1000 : 4'b0000;
            #1;
            if (m == 1) begin
                total++; if (mult_a !== 24'h800000 || mult_b !== 35'h400000000) begin bad++; $display("FAIL ext_ops got=%h/%h want=800000/400000000", mult_a, mult_b); end
            end
            if (m == 5) begin
                total++; if (res_valid !== 4'b0010 || res_p !== e1) begin bad++; $display("FAIL ext_min rv=%b p=%h want 0010/%h", res_valid, res_p, e1); end
            end
            if (m == 6) begin
                total++; if (res_valid !== 4'b1000 || res_p !== e2) begin bad++; $display("FAIL ext_max rv=%b p=%h want 1000/%h", res_valid, res_p, e2); end
            end
            if (m == 7) begin
                total++; if (res_valid !== 4'b0000) begin bad++; $display("FAIL ext_after rv=%b want 0000", res_valid); end
            end
            @(negedge clk);
        end
    endtask

    task automatic test_enable();
        logic [NREQ-1:0] w;
`ifdef MULT_ARB_PRIO_EN
        w = 4'b0001;
`else
        w = 4'b1000;
`endif
        set_op(0, 3, -4); set_op(1, -6, -7);
        for (int m = 0; m <= 16; m++) begin
            en  = (m < 2 || m >= 9) ? 1'b1 : 1'b0;
            req = (m == 0) ? 4'b0001 : (m == 1) ? 4'b0010 : (m < 9) ? 4'b0011 : (m == 9) ? 4'b1011 : 4'b0000;
            #1;
            if (m >= 2 && m < 9) begin
                total++; if (gnt !== 4'b0000) begin bad++; $display("FAIL en_gnt_off m=%0d got=%b want=0000", m, gnt); end
            end
            if (m == 5) begin
                total++; if (res_valid !== 4'b0001 || $signed(res_p) !== -59'sd12) begin bad++; $display("FAIL en_res0 rv=%b p=%0d want 0001/-12", res_valid, $signed(res_p)); end
            end
            if (m == 6) begin
                total++; if (res_valid !== 4'b0010 || $signed(res_p) !== 59'sd42) begin bad++; $display("FAIL en_res1 rv=%b p=%0d want 0010/42", res_valid, $signed(res_p)); end
            end
            if (m == 7) begin
                total++; if (busy !== 1'b0 || res_valid !== 4'b0000) begin bad++; $display("FAIL en_idle busy=%b rv=%b want 0/0000", busy, res_valid); end
            end
            if (m == 9) begin
                total++; if (gnt !== w) begin bad++; $display("FAIL en_resume got=%b want=%b", gnt, w); end
            end
            @(negedge clk);
        end
    endtask

    task automatic test_async_reset();
        set_op(2, 11, 13);
        en = 1'b1;
        for (int m = 0; m <= 11; m++) begin
            req = (m == 10) ? 4'b1010 : (m == 0) ? 4'b0100 : 4'b0000;
            if (m == 2) reset = 1'b1;
            if (m == 3) reset = 1'b0;
            #1;
            if (m == 0) begin
                total++; if (gnt !== 4'b0100) begin bad++; $display("FAIL ar_gnt got=%b want=0100", gnt); end
            end
            if (m == 2) begin
                total++; if (busy !== 1'b0 || mult_a !== '0 || mult_b !== '0 || res_p !== '0) begin bad++; $display("FAIL ar_clear busy=%b a=%h b=%h p=%h want all 0", busy, mult_a, mult_b, res_p); end
            end
            if (m >= 2 && m <= 9) begin
                total++; if (res_valid !== 4'b0000) begin bad++; $display("FAIL ar_no_res m=%0d got=%b want=0000", m, res_valid); end
            end
            if (m == 10) begin
                total++; if (gnt !== 4'b0010) begin bad++; $display("FAIL ar_first_gnt got=%b want=0010", gnt); end
            end
            @(negedge clk);
        end
    endtask

`ifdef MULT_ARB_PRIO_EN
    task automatic test_prio();
        logic [NREQ-1:0] w;
        do_reset();
        for (int m = 0; m <= 6; m++) begin
            req = (m < 4) ? 4'b1111 : 4'b1110;
            #1;
            w = (m < 4) ? 4'b0001 : (4'b0001 << (m - 3));
            total++; if (gnt !== w) begin bad++; $display("FAIL prio_gnt m=%0d got=%b want=%b", m, gnt, w); end
            @(negedge clk);
        end
        req = '0;
    endtask
`endif

    initial begin
        reset = 1'b1; en = 1'b0; req = '0; a_in = '0; b_in = '0;
        @(negedge clk);
        test_reset();
        test_single();
`ifndef MULT_ARB_PRIO_EN
        test_back_to_back();
`endif
        test_extremes();
        test_enable();
        test_async_reset();
`ifdef MULT_ARB_PRIO_EN
        test_prio();
`endif
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
